// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller and execution monitor for the single-cycle CPU core.
//   Holds the CPU clear (cpu_clrn) low for RESET_CYCLES after start, then runs it.
//   It counts RUN cycles and pc changes. It detects a halt loop (pc unchanged for
//   HALT_CYCLES samples) or an exhausted cycle budget (MAX_CYCLES, 0 = unlimited).
//   It keeps a circular trace of the most recent pc changes.
// Ports:
//   clk, clr (async active-high reset), start (one-cycle run request)
//   pc, inst          : CPU program counter and current instruction
//   cpu_clrn          : active-low clear to the CPU
//   running           : high while in RUN
//   halted, timeout   : sticky until the next start
//   cycle_cnt         : RUN cycle count
//   inst_cnt          : pc change count
//   trace_idx         : trace entry to read, 0 = newest
//   trace_pc, trace_inst, trace_valid : registered trace readout
// Build option: define CPU_RUN_CTRL_TRACE_EN to build the trace buffer; otherwise
//   the trace outputs are tied to 0.
module cpu_run_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RESET_CYCLES = 50,
  parameter int HALT_CYCLES  = 8,
  parameter int MAX_CYCLES   = 0,
  parameter int TRACE_DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              pc,
  input  logic [DATA_W-1:0]              inst,
  output logic                           cpu_clrn,
  output logic                           running,
  output logic                           halted,
  output logic                           timeout,
  output logic [31:0]                    cycle_cnt,
  output logic [31:0]                    inst_cnt,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [ADDR_W-1:0]              trace_pc,
  output logic [DATA_W-1:0]              trace_inst,
  output logic                           trace_valid
);
  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int STB_W  = $clog2(HALT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [STB_W-1:0]    stable_q, stable_d;
  logic [31:0]         cycle_q, cycle_d, inst_cnt_q, inst_cnt_d;
  logic                halted_q, halted_d, timeout_q, timeout_d, first_q, first_d;
  logic [ADDR_W-1:0]   pc_q;
  logic                chg, halt_hit, to_hit, wr_en, cnt_clr;
  assign cpu_clrn  = (state_q == RUN) || (state_q == DONE);
  assign running   = state_q == RUN;
  assign halted    = halted_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_q;
  assign inst_cnt  = inst_cnt_q;
  // first_q forces the first RUN sample to count as a pc change
  assign chg      = first_q || (pc != pc_q);
  assign halt_hit = !chg && (stable_q == STB_W'(HALT_CYCLES - 1));
  assign to_hit   = (MAX_CYCLES != 0) && (cycle_q == 32'(MAX_CYCLES - 1));
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stable_d   = stable_q;
    cycle_d    = cycle_q;
    inst_cnt_d = inst_cnt_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    first_d    = first_q;
    wr_en      = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      RESET: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d = RUN;
          first_d = 1'b1;
        end
      end
      RUN: begin
        first_d = 1'b0;
        if (chg) begin
          inst_cnt_d = inst_cnt_q + 32'd1;
          stable_d   = '0;
          wr_en      = 1'b1;
        end else begin
          stable_d = (stable_q == '1) ? stable_q : stable_q + STB_W'(1);
        end
        // cycle_cnt freezes on the exit edge so it shows the last RUN cycle index
        if (halt_hit || to_hit) begin
          state_d   = DONE;
          halted_d  = halt_hit;
          timeout_d = to_hit;
        end else begin
          cycle_d = cycle_q + 32'd1;
        end
      end
      default: ;
    endcase
    if (((state_q == IDLE) || (state_q == DONE)) && start) begin
      state_d    = RESET;
      hold_d     = '0;
      stable_d   = '0;
      cycle_d    = '0;
      inst_cnt_d = '0;
      halted_d   = 1'b0;
      timeout_d  = 1'b0;
      cnt_clr    = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      stable_q   <= '0;
      cycle_q    <= '0;
      inst_cnt_q <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      first_q    <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      stable_q   <= stable_d;
      cycle_q    <= cycle_d;
      inst_cnt_q <= inst_cnt_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      first_q    <= first_d;
      pc_q       <= pc;
    end
  end
`ifdef CPU_RUN_CTRL_TRACE_EN
  localparam int IDX_W = $clog2(TRACE_DEPTH);
  logic [ADDR_W+DATA_W-1:0] trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0]         wr_ptr_q, wr_ptr_d, rd_slot;
  logic [IDX_W:0]           tcnt_q, tcnt_d;
  logic [ADDR_W-1:0]        tpc_q, tpc_d;
  logic [DATA_W-1:0]        tinst_q, tinst_d;
  logic                     tvalid_q, tvalid_d;
  // pointer arithmetic wraps naturally because TRACE_DEPTH is a power of two
  assign rd_slot = wr_ptr_q - IDX_W'(1) - trace_idx;
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + IDX_W'(1) : wr_ptr_q;
    tcnt_d   = cnt_clr ? '0 : (wr_en && tcnt_q != (IDX_W+1)'(TRACE_DEPTH)) ? tcnt_q + (IDX_W+1)'(1) : tcnt_q;
    {tpc_d, tinst_d} = trace_mem[rd_slot];
    tvalid_d = {1'b0, trace_idx} < tcnt_q;
  end
  always_ff @(posedge clk) begin
    if (wr_en) trace_mem[wr_ptr_q] <= {pc, inst};
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      tcnt_q   <= '0;
      tpc_q    <= '0;
      tinst_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      tcnt_q   <= tcnt_d;
      tpc_q    <= tpc_d;
      tinst_q  <= tinst_d;
      tvalid_q <= tvalid_d;
    end
  end
  assign trace_pc    = tpc_q;
  assign trace_inst  = tinst_q;
  assign trace_valid = tvalid_q;
`else
  logic unused;
  assign unused      = ^{trace_idx, inst, wr_en, cnt_clr};
  assign trace_pc    = '0;
  assign trace_inst  = '0;
  assign trace_valid = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;
  logic [1:0]  trace_idx = '0;
  logic        cpu_clrn, running, halted, timeout, trace_valid;
  logic [31:0] cycle_cnt, inst_cnt, trace_pc, trace_inst;
  int          checks = 0;
  int          failures = 0;
  cpu_run_ctrl #(
    .ADDR_W(32), .DATA_W(32), .RESET_CYCLES(4), .HALT_CYCLES(3),
    .MAX_CYCLES(20), .TRACE_DEPTH(4)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .pc(pc), .inst(inst),
    .cpu_clrn(cpu_clrn), .running(running), .halted(halted), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .trace_idx(trace_idx),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_valid(trace_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] p);
    pc   = p;
    inst = p ^ 32'hA5A5_0000;
    tick();
  endtask
  task automatic start_run;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("entry_halted", 64'(halted), 64'(0));
    check("entry_timeout", 64'(timeout), 64'(0));
    check("entry_cycle", 64'(cycle_cnt), 64'(0));
    check("entry_inst", 64'(inst_cnt), 64'(0));
    n = 0;
    while (!running && n < 20) begin
      check("clrn_low", 64'(cpu_clrn), 64'(0));
      tick();
      n++;
    end
    check("hold_len", 64'(n), 64'(4));
    check("clrn_high", 64'(cpu_clrn), 64'(1));
    check("run_cycle0", 64'(cycle_cnt), 64'(0));
  endtask
  task automatic check_trace(input int i, input logic [31:0] p, input logic v);
    trace_idx = 2'(i);
    tick();
`ifdef CPU_RUN_CTRL_TRACE_EN
    check("trace_valid", 64'(trace_valid), 64'(v));
    if (v) begin
      check("trace_pc", 64'(trace_pc), 64'(p));
      check("trace_inst", 64'(trace_inst), 64'(p ^ 32'hA5A5_0000));
    end
`else
    check("trace_valid_off", 64'(trace_valid), 64'(0));
    check("trace_pc_off", 64'(trace_pc), 64'(0));
    check("trace_inst_off", 64'(trace_inst), 64'(0));
`endif
  endtask
  initial begin
    int unsigned hp[7] = '{0, 4, 8, 12, 12, 12, 12};
    clr = 1'b1;
    #1;
    check("rst_clrn", 64'(cpu_clrn), 64'(0));
    check("rst_running", 64'(running), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_cycle", 64'(cycle_cnt), 64'(0));
    check("rst_inst", 64'(inst_cnt), 64'(0));
    check("rst_tvalid", 64'(trace_valid), 64'(0));
    check("rst_tpc", 64'(trace_pc), 64'(0));
    tick();
    tick();
    clr = 1'b0;
    tick();
    check("idle_clrn", 64'(cpu_clrn), 64'(0));
    // halt: pc 0,4,8,12 then holds; third equal sample halts
    start_run();
    for (int k = 0; k < 7; k++) begin
      if (k < 4) check("cycle_seq", 64'(cycle_cnt), 64'(k));
      check("halt_running", 64'(running), 64'(1));
      drive(hp[k]);
    end
    check("halt_flag", 64'(halted), 64'(1));
    check("halt_timeout", 64'(timeout), 64'(0));
    check("halt_running_off", 64'(running), 64'(0));
    check("halt_clrn", 64'(cpu_clrn), 64'(1));
    check("halt_inst", 64'(inst_cnt), 64'(4));
    check("halt_cycle", 64'(cycle_cnt), 64'(6));
    tick();
    tick();
    check("halt_frozen", 64'(cycle_cnt), 64'(6));
    check("halt_sticky", 64'(halted), 64'(1));
    // timeout: pc changes every cycle, a start during RUN is ignored
    start_run();
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        check("start_ignored_run", 64'(running), 64'(1));
        check("start_ignored_cyc", 64'(cycle_cnt), 64'(10));
      end
      start = (k == 5);
      drive(32'(k * 4));
      start = 1'b0;
    end
    check("to_flag", 64'(timeout), 64'(1));
    check("to_halted", 64'(halted), 64'(0));
    check("to_cycle", 64'(cycle_cnt), 64'(19));
    check("to_inst", 64'(inst_cnt), 64'(20));
    check("to_running", 64'(running), 64'(0));
    // halt and timeout on the same edge
    start_run();
    for (int k = 0; k < 20; k++) drive(32'((k < 16 ? k : 16) * 4));
    check("both_halted", 64'(halted), 64'(1));
    check("both_timeout", 64'(timeout), 64'(1));
    check("both_inst", 64'(inst_cnt), 64'(17));
    check("both_cycle", 64'(cycle_cnt), 64'(19));
    // trace wrap: 7 changes into a 4-entry buffer
    start_run();
    for (int k = 0; k < 10; k++) drive(32'((k < 6 ? k : 6) * 4));
    check("tr_halted", 64'(halted), 64'(1));
    check("tr_inst", 64'(inst_cnt), 64'(7));
    for (int i = 0; i < 4; i++) check_trace(i, 32'(24 - 4 * i), 1'b1);
    // restart with only two changes
    start_run();
    for (int k = 0; k < 5; k++) drive(32'((k < 1 ? k : 1) * 4));
    check("tr2_halted", 64'(halted), 64'(1));
    check("tr2_inst", 64'(inst_cnt), 64'(2));
    check_trace(0, 32'd4, 1'b1);
    check_trace(1, 32'd0, 1'b1);
    check_trace(2, 32'd0, 1'b0);
    // async clr mid-RUN
    start_run();
    for (int k = 0; k < 3; k++) drive(32'(k * 4 + 100));
    #2;
    clr = 1'b1;
    #1;
    check("clr_clrn", 64'(cpu_clrn), 64'(0));
    check("clr_running", 64'(running), 64'(0));
    check("clr_cycle", 64'(cycle_cnt), 64'(0));
    check("clr_inst", 64'(inst_cnt), 64'(0));
    check("clr_tvalid", 64'(trace_valid), 64'(0));
    tick();
    clr = 1'b0;
    tick();
    tick();
    check("clr_idle_clrn", 64'(cpu_clrn), 64'(0));
    check("clr_idle_running", 64'(running), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller and execution monitor for the single-cycle CPU core, used in simulation and on-board bring-up. It sequences the CPU's active-low clear with a parameterised hold time. It watches the CPU's `pc`/`inst` outputs to count cycles and executed instructions. It detects a halt loop or a cycle-budget timeout and keeps a circular trace of the most recent program-counter changes for post-mortem readout.

## Interface
Parameters:
- `ADDR_W`, 32, width of `pc`
- `DATA_W`, 32, width of `inst`
- `RESET_CYCLES`, 50, cycles `cpu_clrn` is held low per run (≥1)
- `HALT_CYCLES`, 8, consecutive unchanged-pc samples that declare a halt (≥2)
- `MAX_CYCLES`, 0, run-cycle budget; 0 = unlimited
- `TRACE_DEPTH`, 16, trace entries, power of two (≥2)

Ports:
- `clk` in 1: single clock, rising edge
- `clr` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle run request
- `pc` in ADDR_W: CPU program counter
- `inst` in DATA_W: CPU current instruction
- `cpu_clrn` out 1: active-low clear to the CPU's `clrn`
- `running` out 1: high while in RUN
- `halted` out 1: halt loop detected, sticky until next start
- `timeout` out 1: budget exhausted, sticky until next start
- `cycle_cnt` out 32: RUN cycles elapsed
- `inst_cnt` out 32: pc changes observed in RUN
- `trace_idx` in log2(TRACE_DEPTH): 0 = newest entry
- `trace_pc` out ADDR_W, `trace_inst` out DATA_W, `trace_valid` out 1: registered trace readout

## Operation
- States: IDLE, RESET, RUN, DONE. Reset state is IDLE.
- IDLE: `cpu_clrn`=0. `start` → RESET.
- RESET: `cpu_clrn`=0. The hold counter runs 0..RESET_CYCLES-1, then → RUN. On entry, clears `cycle_cnt`, `inst_cnt`, `halted`, `timeout`, the stable counter and the trace count.
- RUN: `cpu_clrn`=1 and `running`=1. `cycle_cnt` increments every cycle.
- RUN, pc tracking: `pc` is registered into `pc_q`. On the first RUN cycle, or whenever `pc`≠`pc_q`, `inst_cnt` increments and {`pc`,`inst`} is written to the trace. Otherwise the stable counter increments, saturating.
- RUN, halt: the stable counter reaching HALT_CYCLES-1 on an equal sample → DONE with `halted`=1.
- RUN, timeout: if MAX_CYCLES≠0 and `cycle_cnt`==MAX_CYCLES-1 → DONE with `timeout`=1.
- Halt and timeout on the same edge: both flags set.
- DONE: `cpu_clrn` stays 1. Counters are frozen. `start` → RESET.
- `start` in RESET or RUN is ignored.
- Counters are 32-bit and wrap modulo 2^32.
- Trace: circular write pointer increments per write and wraps at TRACE_DEPTH-1→0. The entry count saturates at TRACE_DEPTH. Entry `trace_idx` reads slot (wr_ptr-1-trace_idx) mod TRACE_DEPTH. `trace_valid` = trace_idx < count.
- `clr` mid-run: immediately forces IDLE and all reset values. `cpu_clrn` drops asynchronously.

## Timing
- Reset values: `cpu_clrn`=0, `running`=0, `halted`=0, `timeout`=0, `cycle_cnt`=0, `inst_cnt`=0, `trace_pc`=0, `trace_inst`=0, `trace_valid`=0.
- `start` sampled at edge N → RESET from N. `cpu_clrn` is low for exactly RESET_CYCLES cycles after N, then rises together with `running`.
- Halt: `halted` rises on the edge where the HALT_CYCLES-th consecutive equal sample is taken. `running` falls on the same edge.
- Trace readout latency: 1 cycle from `trace_idx` to outputs.
- A write and a read of the same slot in one cycle returns the old data.

## Configuration
- `CPU_RUN_CTRL_TRACE_EN` defined: trace buffer and readout logic are built.
- Undefined: no trace storage. `trace_pc`, `trace_inst` and `trace_valid` are tied 0. Counters, halt detection and timeout are unchanged.

## Test plan
- Reset release: RESET_CYCLES=4, pulse `start` → `cpu_clrn` low for exactly 4 cycles, then `running`=1 and `cycle_cnt` counts 0,1,2…
- Halt: pc steps 0,4,8,12 then holds 12, HALT_CYCLES=3 → `inst_cnt`=4, `halted`=1 on the 3rd equal sample, `cycle_cnt` frozen.
- Timeout: MAX_CYCLES=20, pc increments every cycle → `timeout`=1 with `cycle_cnt`=19. Halt arranged on the same edge → both flags set.
- Trace wrap: TRACE_DEPTH=4, pcs 0,4,…,24 (7 changes) → idx0=24, idx3=12, all `trace_valid`=1. After a restart with 2 changes, idx2 has `trace_valid`=0.
- Async `clr` mid-RUN → same-cycle `cpu_clrn`=0, all outputs at reset values, state IDLE. `start` during RUN ignored.
- Build without `CPU_RUN_CTRL_TRACE_EN` → trace outputs constant 0, halt test results unchanged.
